// File: rtl/alu_issue_stage_pkg.sv
// Shared decode constants, ALU control encodings and the issue-entry type
// for the ALU issue stage.
package alu_issue_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;

    localparam logic [6:0] R_TYPE        = 7'b0110011;
    localparam logic [6:0] I_TYPE_OP_IMM = 7'b0010011;
    localparam logic [6:0] I_TYPE_LOAD   = 7'b0000011;
    localparam logic [6:0] S_TYPE        = 7'b0100011;
    localparam logic [6:0] B_TYPE        = 7'b1100011;
    localparam logic [6:0] LUI           = 7'b0110111;
    localparam logic [6:0] AUIPC         = 7'b0010111;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic [DATA_W-1:0] opr1;
        logic [DATA_W-1:0] opr2;
        logic [3:0]        alu_ctrl;
        logic [TAG_W-1:0]  rd;
        logic              is_branch;
        logic [2:0]        br_funct3;
        logic              illegal;
    } issue_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (register-read) and downstream (ALU) handshake bundle of the
// issue stage; master is the stage itself, slave is its environment.
interface alu_issue_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] opr1;
    logic [XLEN-1:0] opr2;
    logic [3:0]      alu_ctrl;
    logic [RD_W-1:0] rd;
    logic            is_branch;
    logic [2:0]      br_funct3;
    logic            illegal;

    modport master (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, opr1, opr2, alu_ctrl, rd, is_branch, br_funct3, illegal
    );

    modport slave (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, opr1, opr2, alu_ctrl, rd, is_branch, br_funct3, illegal
    );
endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I decode: instruction and register reads into an ALU
// issue entry (control code, formatted operands, rd tag, branch/illegal flags).
module alu_issue_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output issue_entry_t      entry
);
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_u;
    logic [DATA_W-1:0] shamt_reg;
    logic [DATA_W-1:0] shamt_imm;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_s     = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u     = {instr[31:12], 12'b0};
    // The ALU shifts by the full operand, so shift amounts are masked here.
    assign shamt_reg = {{(DATA_W-5){1'b0}}, rs2_data[4:0]};
    assign shamt_imm = {{(DATA_W-5){1'b0}}, instr[24:20]};

    always_comb begin
        entry    = '0;
        entry.rd = instr[11:7];
        case (opcode)
            R_TYPE: begin
                entry.opr1 = rs1_data;
                entry.opr2 = (funct3 == FUNCT3_SLL || funct3 == FUNCT3_SRL_SRA) ? shamt_reg : rs2_data;
                if (funct7 == FUNCT7_BASE)
                    entry.alu_ctrl = {1'b0, funct3};
                else if (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_ADD_SUB || funct3 == FUNCT3_SRL_SRA))
                    entry.alu_ctrl = {1'b1, funct3};
                else
                    entry.illegal = 1'b1;
            end
            I_TYPE_OP_IMM: begin
                entry.opr1     = rs1_data;
                entry.opr2     = imm_i;
                entry.alu_ctrl = {1'b0, funct3};
                if (funct3 == FUNCT3_SRL_SRA) begin
                    entry.opr2     = shamt_imm;
                    entry.alu_ctrl = {instr[30], funct3};
                    entry.illegal  = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                end else if (funct3 == FUNCT3_SLL) begin
                    entry.illegal = (funct7 != FUNCT7_BASE);
                end
            end
            I_TYPE_LOAD: begin
                entry.opr1 = rs1_data;
                entry.opr2 = imm_i;
            end
            S_TYPE: begin
                entry.opr1 = rs1_data;
                entry.opr2 = imm_s;
                entry.rd   = '0;
            end
            B_TYPE: begin
                entry.opr1      = rs1_data;
                entry.opr2      = rs2_data;
                entry.rd        = '0;
                entry.is_branch = 1'b1;
                entry.br_funct3 = funct3;
                case (funct3)
                    FUNCT3_BEQ, FUNCT3_BNE:   entry.alu_ctrl = ALU_SUB;
                    FUNCT3_BLT, FUNCT3_BGE:   entry.alu_ctrl = ALU_SLT;
                    FUNCT3_BLTU, FUNCT3_BGEU: entry.alu_ctrl = ALU_SLTU;
                    default:                  entry.illegal  = 1'b1;
                endcase
            end
            LUI: begin
                entry.opr2 = imm_u;
            end
            AUIPC: begin
                entry.opr1 = pc;
                entry.opr2 = imm_u;
            end
            default: begin
                entry.illegal = 1'b1;
                entry.rd      = '0;
            end
        endcase
        if (entry.illegal)
            entry.alu_ctrl = ALU_ADD;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes on the input side and holds up to two entries
// (main + skid) so that in_ready comes straight from a flop.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    alu_issue_stage_if.master bus
);
    buf_state_t   state_q, state_d;
    issue_entry_t main_q, skid_q, dec_entry;
    logic         accept, drain;
    logic         main_load_in, main_load_skid, skid_load;

    alu_issue_decode u_decode (
        .instr    (bus.instr),
        .pc       (bus.pc),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .entry    (dec_entry)
    );

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= BUF_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (accept) state_d = BUF_ONE;
                BUF_ONE: begin
                    if (accept && !drain)
                        state_d = BUF_FULL;
                    else if (!accept && drain)
                        state_d = BUF_EMPTY;
                end
                BUF_FULL:  if (drain) state_d = BUF_ONE;
                default:   state_d = BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state_q != BUF_FULL);
        bus.out_valid = (state_q != BUF_EMPTY);
        bus.opr1      = '0;
        bus.opr2      = '0;
        bus.alu_ctrl  = '0;
        bus.rd        = '0;
        bus.is_branch = 1'b0;
        bus.br_funct3 = '0;
        bus.illegal   = 1'b0;
        if (state_q != BUF_EMPTY) begin
            bus.opr1      = XLEN'(main_q.opr1);
            bus.opr2      = XLEN'(main_q.opr2);
            bus.alu_ctrl  = main_q.alu_ctrl;
            bus.rd        = RD_W'(main_q.rd);
            bus.is_branch = main_q.is_branch;
            bus.br_funct3 = main_q.br_funct3;
            bus.illegal   = main_q.illegal;
        end
    end

    // Flush only moves the state to EMPTY; stale payload is masked at the output.
    assign main_load_in   = !flush && accept && (state_q == BUF_EMPTY || (state_q == BUF_ONE && drain));
    assign main_load_skid = !flush && drain && (state_q == BUF_FULL);
    assign skid_load      = !flush && accept && !drain && (state_q == BUF_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load_in)
                main_q <= dec_entry;
            else if (main_load_skid)
                main_q <= skid_q;
            if (skid_load)
                skid_q <= dec_entry;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps plus randomized traffic checked
// against a FIFO-of-decoded-entries reference model.
module tb_alu_issue_stage;
    logic clk;
    logic rst;
    logic flush;
    int   tests;
    int   fails;

    typedef struct {
        logic [31:0] o1;
        logic [31:0] o2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        br;
        logic [2:0]  bf3;
        logic        ill;
    } exp_t;

    exp_t q[$];

    alu_issue_stage_if #(.XLEN(32), .RD_W(5)) bus ();

    alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int unsigned op, f3, f7;
        logic [31:0] imm_i, imm_s, imm_u;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        imm_u = ins & 32'hFFFF_F000;
        e = '{o1: 32'd0, o2: 32'd0, ctrl: 4'd0, rd: ins[11:7], br: 1'b0, bf3: 3'd0, ill: 1'b0};
        case (op)
            'h33: begin
                e.o1 = a;
                e.o2 = (f3 == 1 || f3 == 5) ? b % 32 : b;
                if (f7 == 0) e.ctrl = 4'(f3);
                else if (f7 == 32 && (f3 == 0 || f3 == 5)) e.ctrl = 4'(8 + f3);
                else e.ill = 1'b1;
            end
            'h13: begin
                e.o1   = a;
                e.o2   = imm_i;
                e.ctrl = 4'(f3);
                if (f3 == 1 && f7 != 0) e.ill = 1'b1;
                if (f3 == 5) begin
                    e.o2 = 32'(ins[24:20]);
                    if (f7 == 32) e.ctrl = 4'd13;
                    else if (f7 != 0) e.ill = 1'b1;
                end
            end
            'h03: begin e.o1 = a; e.o2 = imm_i; end
            'h23: begin e.o1 = a; e.o2 = imm_s; e.rd = 5'd0; end
            'h63: begin
                e.o1 = a; e.o2 = b; e.rd = 5'd0; e.br = 1'b1; e.bf3 = 3'(f3);
                if (f3 <= 1) e.ctrl = 4'd8;
                else if (f3 == 4 || f3 == 5) e.ctrl = 4'd2;
                else if (f3 >= 6) e.ctrl = 4'd3;
                else e.ill = 1'b1;
            end
            'h37: e.o2 = imm_u;
            'h17: begin e.o1 = pc; e.o2 = imm_u; end
            default: begin e.ill = 1'b1; e.rd = 5'd0; end
        endcase
        if (e.ill) e.ctrl = 4'd0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.pc        = $urandom;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    // One clock: compare DUT against the model, then advance the model.
    task automatic tick();
        logic acc, drn;
        exp_t e;
        @(negedge clk);
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("opr1", bus.opr1, q[0].o1);
            chk("opr2", bus.opr2, q[0].o2);
            chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(q[0].ctrl));
            chk("rd", 32'(bus.rd), 32'(q[0].rd));
            chk("is_branch", 32'(bus.is_branch), 32'(q[0].br));
            chk("br_funct3", 32'(bus.br_funct3), 32'(q[0].bf3));
            chk("illegal", 32'(bus.illegal), 32'(q[0].ill));
        end
        acc = bus.in_valid && (q.size() < 2);
        drn = bus.out_ready && (q.size() > 0);
        e   = ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [7];
        int unsigned pick;
        ops  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17};
        ins  = $urandom;
        pick = $urandom_range(0, 8);
        if (pick < 7) ins[6:0] = ops[pick];
        if ((ins[6:0] == 7'h33 || (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)))
            && $urandom_range(0, 3) != 0)
            ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #3;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset opr1", bus.opr1, 32'd0);
        chk("reset opr2", bus.opr2, 32'd0);
        chk("reset alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("reset rd", 32'(bus.rd), 32'd0);
        chk("reset illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0);
        tick();
        chk("add out_valid", 32'(bus.out_valid), 32'd1);
        chk("add alu_ctrl", 32'(bus.alu_ctrl), 32'h0);
        chk("add opr1", bus.opr1, 32'd5);
        chk("add opr2", bus.opr2, 32'd7);
        chk("add rd", 32'(bus.rd), 32'd3);

        // srai then sll, back to back
        drive(1'b1, 32'h40435293, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        tick();
        chk("srai alu_ctrl", 32'(bus.alu_ctrl), 32'hD);
        chk("srai opr2", bus.opr2, 32'd4);
        drive(1'b1, 32'h003110B3, 32'd9, 32'h21, 1'b1, 1'b0);
        tick();
        chk("sll alu_ctrl", 32'(bus.alu_ctrl), 32'h1);
        chk("sll opr2", bus.opr2, 32'd1);

        // bltu then beq
        drive(1'b1, 32'h0020E063, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        chk("bltu is_branch", 32'(bus.is_branch), 32'd1);
        chk("bltu alu_ctrl", 32'(bus.alu_ctrl), 32'h3);
        chk("bltu rd", 32'(bus.rd), 32'd0);
        chk("bltu br_funct3", 32'(bus.br_funct3), 32'd6);
        drive(1'b1, 32'h00208063, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        chk("beq alu_ctrl", 32'(bus.alu_ctrl), 32'h8);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();

        // Back-pressure: A, B, C with the ALU stalled
        drive(1'b1, 32'h002081B3, 32'h11, 32'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h002081B3, 32'h22, 32'd2, 1'b0, 1'b0);
        tick();
        chk("bp A held", bus.opr1, 32'h11);
        chk("bp in_ready after B", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h002081B3, 32'h33, 32'd3, 1'b0, 1'b0);
        tick();
        chk("bp A still held", bus.opr1, 32'h11);
        bus.out_ready = 1'b1;
        tick();
        chk("bp B second", bus.opr1, 32'h22);
        tick();
        chk("bp C third", bus.opr1, 32'h33);
        bus.in_valid = 1'b0;
        tick();
        chk("bp drained", 32'(bus.out_valid), 32'd0);

        // Flush while FULL with a live input
        drive(1'b1, 32'h002081B3, 32'h44, 32'd4, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 32'h002081B3, 32'h55, 32'd5, 1'b1, 1'b1);
        tick();
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();

        // Illegal encodings
        drive(1'b1, 32'h0000007F, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        chk("bad opcode illegal", 32'(bus.illegal), 32'd1);
        chk("bad opcode alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        drive(1'b1, 32'h4020C1B3, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        chk("bad funct7 illegal", 32'(bus.illegal), 32'd1);
        chk("bad funct7 alu_ctrl", 32'(bus.alu_ctrl), 32'd0);

        // Asynchronous reset with entries held
        drive(1'b1, 32'h002081B3, 32'h66, 32'd6, 1'b0, 1'b0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst opr1", bus.opr1, 32'd0);
        chk("async rst rd", 32'(bus.rd), 32'd0);
        chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered ID/EX boundary that drives the ALU operand and control interface: opr1, opr2 and alu_ctrl.
- Decodes a 32-bit RV32I instruction into the 4-bit alu_ctrl code {funct7[5], funct3}, selects and formats the operands, and presents them one cycle later.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so in_ready is a registered signal.
- Sits between the register-file read stage and the ALU.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the rd/shamt decode requires it.
- RD_W, 5, width of the destination-register tag passed through to the output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- instr  in  32  instruction word.
- pc  in  XLEN  instruction address.
- rs1_data  in  XLEN  register-file read of rs1.
- rs2_data  in  XLEN  register-file read of rs2.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream (ALU/EX) accepts.
- opr1  out  XLEN  ALU operand 1.
- opr2  out  XLEN  ALU operand 2.
- alu_ctrl  out  4  ALU control code {funct7[5], funct3}.
- rd  out  RD_W  destination register (instr[11:7]).
- is_branch  out  1  conditional branch; downstream resolves it using the ALU result/zero.
- br_funct3  out  3  branch condition (instr[14:12]).
- illegal  out  1  undecodable instruction.

Behaviour:
- Reset (asynchronous, rst=1): every output register and both buffer entries clear to 0. out_valid=0, so opr1, opr2, alu_ctrl, rd, is_branch, br_funct3 and illegal all read 0. in_ready=1 whenever the skid entry is empty, including during reset.

Decode (combinational on the input side, registered on accept):
- R-type, 0110011:
  - funct7=0000000: alu_ctrl={0,funct3}.
  - funct7=0100000 with funct3 in {000,101}: alu_ctrl={1,funct3}, i.e. SUB=1000, SRA=1101.
  - Any other funct7/funct3 combination sets illegal.
  - opr1=rs1_data. opr2=rs2_data, except shifts (funct3 001/101), where opr2={27'b0, rs2_data[4:0]}. The ALU does not mask shift amounts; this stage must.
- OP-IMM, 0010011: opr1=rs1_data, opr2=sign-extended I-immediate.
  - funct3=101: alu_ctrl={instr[30],101}, opr2={27'b0, instr[24:20]}.
  - SLLI/SRLI/SRAI with instr[31:25] not equal to 0000000 (or 0100000 for SRAI) set illegal.
  - All other funct3: alu_ctrl={0,funct3}.
- LOAD, 0000011: alu_ctrl=0000, opr1=rs1_data, opr2=I-immediate.
- STORE, 0100011: alu_ctrl=0000, opr1=rs1_data, opr2=S-immediate; rd forced to 0.
- BRANCH, 1100011: is_branch=1, opr1=rs1_data, opr2=rs2_data, rd=0.
  - funct3 000/001 -> alu_ctrl=1000 (SUB).
  - 100/101 -> 0010 (SLT).
  - 110/111 -> 0011 (SLTU).
  - 010/011 set illegal.
- LUI, 0110111: opr1=0, opr2={instr[31:12],12'b0}, alu_ctrl=0000.
- AUIPC, 0010111: opr1=pc, opr2=U-immediate, alu_ctrl=0000.
- Any other opcode: illegal=1, alu_ctrl=0, opr1=opr2=0, rd=0.
- An illegal entry still flows through the handshake; downstream traps on it.

Handshake and buffering:
- Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
- Output fields must not change while out_valid && !out_ready.
- Latency: an accepted entry appears on the outputs the next cycle if the main register is empty or draining.
- Buffer states: EMPTY (main invalid), ONE (main valid), FULL (main and skid valid).
  - EMPTY: on accept -> ONE.
  - ONE: accept without drain -> FULL (entry goes to skid). Accept with drain -> ONE (new entry goes to main). Drain only -> EMPTY.
  - FULL: in_ready=0. On drain, skid moves to main -> ONE.
- in_ready = !skid_valid (registered only).
- flush=1: main and skid are invalidated at the next edge, and an input presented in the same cycle is discarded. Flush has priority over accept and drain.
- rst asserted mid-transfer drops all entries immediately.

Decomposition:
- Shared package holds:
  - opcode constants: R_TYPE, I_TYPE_OP_IMM, I_TYPE_LOAD, S_TYPE, B_TYPE, LUI, AUIPC;
  - FUNCT3_* and FUNCT7_* constants;
  - the ALU control encodings {funct7[5], funct3}.
- One combinational sub-module, alu_issue_decode (instr/pc/rs data -> decoded entry). The top level holds the 2-entry skid buffer only.

Test Plan:
1. add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0000, opr1=5, opr2=7, rd=3.
2. srai x5,x6,4 (0x40435293), rs1=0x80000000 -> alu_ctrl=1101, opr2=4; sll x1,x2,x3 with rs2=0x00000021 -> alu_ctrl=0001, opr2=1.
3. bltu x1,x2 (funct3=110), rs1=1, rs2=2 -> is_branch=1, alu_ctrl=0011, rd=0; beq -> alu_ctrl=1000.
4. Back-pressure: out_ready=0, three back-to-back valid inputs A,B,C -> A held stable on the outputs, B captured in skid, in_ready=0 the cycle after B is accepted, C not accepted; raise out_ready -> A, B, C delivered in order with no loss or duplication.
5. FULL state with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input is never output.
6. Opcode 0x0000007F, and R-type funct7=0100000 with funct3=100 -> illegal=1, alu_ctrl=0000; assert rst mid-stream -> all outputs 0 immediately (asynchronous).
